// File: rtl/nor_gate_pkg.sv
// Shared constants and helpers for the NOR gate block: default widths and a
// saturating increment used by the observation counter.
package nor_gate_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 16;

    // Returns value+1, or holds at 2^width-1 once that ceiling is reached.
    // The ceiling check is done before the add so the result never wraps.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_val;
        max_val = (64'd1 << width) - 64'd1;
        if (value >= max_val) begin
            sat_inc = max_val;
        end else begin
            sat_inc = value + 64'd1;
        end
    endfunction

endpackage

// File: rtl/nor_gate_df_sat_counter.sv
// Unsigned up-counter with enable and synchronous clear that sticks at its
// all-ones value instead of wrapping.
module sat_counter
    import nor_gate_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= W'(sat_inc(64'(r_cnt), W));
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/nor_gate_df.sv
// Dataflow bitwise NOR with a clocked observation stage: registered copy of y,
// rise/fall pulses on bit 0 and a saturating count of edges where y[0] was high.
module nor_gate_df
    import nor_gate_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] y_q,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] hi_cnt
);

    logic [WIDTH-1:0] r_y_q;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] w_hi_cnt;

    // Purely combinational path; clk and rst never touch it.
    assign y = ~(a | b);

    // Edge flags compare the new sample against the previous registered bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_y_q  <= y;
            r_rise <= ~r_y_q[0] & y[0];
            r_fall <= r_y_q[0] & ~y[0];
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_hi_cnt (
        .clk   (clk),
        .srst  (rst),
        .i_en  (y[0]),
        .o_cnt (w_hi_cnt)
    );

    assign y_q    = r_y_q;
    assign rise   = r_rise;
    assign fall   = r_fall;
    assign hi_cnt = w_hi_cnt;

endmodule

// File: tb/tb_nor_gate_df.sv
// Randomised scoreboard bench for nor_gate_df: three instances (default, 3-bit
// counter, 4-bit wide) driven in lockstep and checked against a behavioural model.
module tb_nor_gate_df;

    typedef struct packed {
        logic [3:0]  yq;
        logic        rise;
        logic        fall;
        logic [15:0] cnt;
    } obs_t;

    typedef obs_t [2:0] exp_t;

    logic        clk;
    logic        rst;
    logic        a1, b1, y1, yq1, rise1, fall1;
    logic [15:0] cnt1;
    logic        a3, b3, y3, yq3, rise3, fall3;
    logic [2:0]  cnt3;
    logic [3:0]  a4, b4, y4, yq4;
    logic        rise4, fall4;
    logic [15:0] cnt4;

    int n_err = 0;
    int n_chk = 0;

    exp_t        exp_q[$];
    logic [3:0]  sa[3];
    logic [3:0]  sb[3];
    logic [3:0]  ym[3];
    logic [3:0]  m_yq[3];
    int unsigned m_cnt[3];

    nor_gate_df #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .y(y1), .a(a1), .b(b1), .clk(clk), .rst(rst),
        .y_q(yq1), .rise(rise1), .fall(fall1), .hi_cnt(cnt1)
    );

    nor_gate_df #(.WIDTH(1), .CNT_W(3)) u_dut3 (
        .y(y3), .a(a3), .b(b3), .clk(clk), .rst(rst),
        .y_q(yq3), .rise(rise3), .fall(fall3), .hi_cnt(cnt3)
    );

    nor_gate_df #(.WIDTH(4), .CNT_W(16)) u_dut4 (
        .y(y4), .a(a4), .b(b4), .clk(clk), .rst(rst),
        .y_q(yq4), .rise(rise4), .fall(fall4), .hi_cnt(cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] width_mask(input int i);
        return (i == 2) ? 4'hF : 4'h1;
    endfunction

    function automatic int unsigned cnt_max(input int i);
        return (i == 1) ? 32'd7 : 32'd65535;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Apply sa/sb and rst at the falling edge, predict the next-edge state from
    // the behavioural rules, queue it, then check the combinational outputs.
    task automatic step(input logic r);
        exp_t e;
        @(negedge clk);
        rst = r;
        a1 = sa[0][0]; b1 = sb[0][0];
        a3 = sa[1][0]; b3 = sb[1][0];
        a4 = sa[2];    b4 = sb[2];
        for (int i = 0; i < 3; i++) begin
            ym[i] = ~(sa[i] | sb[i]) & width_mask(i);
            if (r) begin
                e[i].rise = 1'b0;
                e[i].fall = 1'b0;
                m_yq[i]   = 4'h0;
                m_cnt[i]  = 0;
            end else begin
                e[i].rise = (m_yq[i][0] == 1'b0) && (ym[i][0] == 1'b1);
                e[i].fall = (m_yq[i][0] == 1'b1) && (ym[i][0] == 1'b0);
                if (ym[i][0] && m_cnt[i] < cnt_max(i)) m_cnt[i] = m_cnt[i] + 1;
                m_yq[i] = ym[i];
            end
            e[i].yq  = m_yq[i];
            e[i].cnt = 16'(m_cnt[i]);
        end
        exp_q.push_back(e);
        #1;
        chk("y_w1", 32'(y1), 32'(ym[0][0]));
        chk("y_c3", 32'(y3), 32'(ym[1][0]));
        chk("y_w4", 32'(y4), 32'(ym[2]));
    endtask

    task automatic set_all(input logic [3:0] av, input logic [3:0] bv);
        for (int i = 0; i < 3; i++) begin
            sa[i] = av & width_mask(i);
            sb[i] = bv & width_mask(i);
        end
    endtask

    // Monitor: one expectation consumed per clock edge once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("yq_w1",   32'(yq1),   32'(e[0].yq[0]));
                chk("rise_w1", 32'(rise1), 32'(e[0].rise));
                chk("fall_w1", 32'(fall1), 32'(e[0].fall));
                chk("cnt_w1",  32'(cnt1),  32'(e[0].cnt));
                chk("yq_c3",   32'(yq3),   32'(e[1].yq[0]));
                chk("rise_c3", 32'(rise3), 32'(e[1].rise));
                chk("fall_c3", 32'(fall3), 32'(e[1].fall));
                chk("cnt_c3",  32'(cnt3),  32'(e[1].cnt));
                chk("yq_w4",   32'(yq4),   32'(e[2].yq));
                chk("rise_w4", 32'(rise4), 32'(e[2].rise));
                chk("fall_w4", 32'(fall4), 32'(e[2].fall));
                chk("cnt_w4",  32'(cnt4),  32'(e[2].cnt));
            end
        end
    end

    initial begin
        rst = 1'b1;
        a3 = 1'b0; b3 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        for (int i = 0; i < 3; i++) begin
            m_yq[i] = 4'h0;
            m_cnt[i] = 0;
        end

        // Truth table on the default instance at t = 0, 10, 30, 70 ns.
        a1 = 1'b0; b1 = 1'b0; #1 chk("tt_00", 32'(y1), 32'd1);
        #9  a1 = 1'b0; b1 = 1'b1; #1 chk("tt_01", 32'(y1), 32'd0);
        #19 a1 = 1'b1; b1 = 1'b0; #1 chk("tt_10", 32'(y1), 32'd0);
        #39 a1 = 1'b1; b1 = 1'b1; #1 chk("tt_11", 32'(y1), 32'd0);

        // Reset for two edges, then release: rise, then fall on a=1.
        set_all(4'h0, 4'h0);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        set_all(4'hF, 4'h0);
        step(1'b0);

        // Counting: five high edges then three low edges on a fresh count.
        set_all(4'h0, 4'h0);
        step(1'b1);
        repeat (5) step(1'b0);
        @(posedge clk); #1 chk("count5", 32'(cnt1), 32'd5);
        set_all(4'hF, 4'h0);
        repeat (3) step(1'b0);
        @(posedge clk); #1 chk("count_hold", 32'(cnt1), 32'd5);

        // Saturation of the 3-bit counter, then a single reset edge.
        set_all(4'h0, 4'h0);
        step(1'b1);
        repeat (10) step(1'b0);
        @(posedge clk); #1 chk("sat7", 32'(cnt3), 32'd7);
        step(1'b1);
        @(posedge clk); #1 chk("sat_clr", 32'(cnt3), 32'd0);

        // Wide instance directed vector.
        set_all(4'h0, 4'h0);
        sa[2] = 4'b0011;
        sb[2] = 4'b0101;
        step(1'b0);
        chk("w4_y", 32'(y4), 32'h8);
        @(posedge clk); #1 chk("w4_yq", 32'(yq4), 32'h8);

        // Random traffic with occasional resets; the 3-bit instance is biased
        // towards y=1 so it reaches and sits at saturation.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 3; i++) begin
                sa[i] = 4'($urandom) & width_mask(i);
                sb[i] = 4'($urandom) & width_mask(i);
            end
            if ($urandom_range(0, 3) != 0) begin
                sa[1] = 4'h0;
                sb[1] = 4'h0;
            end
            step($urandom_range(0, 29) == 0);
        end

        @(posedge clk);
        #2;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
